// File: rtl/shift_sequencer.sv
// Multi-cycle ARM operand-2 shifter: LSL/LSR/ASR/ROR/RRX with carry-out,
// at most STEP bit positions per cycle, valid/ready on request and result.
module shift_sequencer #(
    parameter int STEP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_data,
    input  logic [7:0]  req_amount,
    input  logic        req_carry_in,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_carry,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_t;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t        state, state_next;
    shift_t        work_type;
    logic [31:0]   work_data;
    logic          work_carry;
    logic [5:0]    remaining;

    shift_t        req_type;
    logic          req_reg;
    logic          is_rrx;
    logic [5:0]    eff_count;

    logic [5:0]    step_k;
    logic [32:0]   lsl_ext;
    logic [32:0]   lsr_ext;
    logic signed [32:0] asr_ext;
    logic [31:0]   ror_data;
    logic [31:0]   step_data;
    logic          step_carry;

    // Effective shift count; counts past 32 are clamped so the step loop
    // naturally produces the architectural over-shift results.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        req_type  = shift_t'(req_op[2:1]);
        req_reg   = req_op[0];
        is_rrx    = 1'b0;
        eff_count = 6'd0;
        if (req_reg) begin
            case (req_type)
                SH_LSL, SH_LSR: eff_count = (req_amount > 8'd33) ? 6'd33 : req_amount[5:0];
                SH_ASR:         eff_count = (req_amount > 8'd32) ? 6'd32 : req_amount[5:0];
                default:        eff_count = (req_amount[4:0] == 5'd0) ? 6'd32 : {1'b0, req_amount[4:0]};
            endcase
            if (req_amount == 8'd0)
                eff_count = 6'd0;
        end else begin
            eff_count = {1'b0, req_amount[4:0]};
            if (req_amount[4:0] == 5'd0) begin
                case (req_type)
                    SH_LSR, SH_ASR: eff_count = 6'd32;
                    SH_ROR:         is_rrx    = 1'b1;
                    default:        eff_count = 6'd0;
                endcase
            end
        end
    end

    // One step of up to STEP positions; the extra bit of each extended
    // vector catches the last bit shifted out.
    always_comb begin
        step_k   = (remaining < STEP_W) ? remaining : STEP_W;
        lsl_ext  = {1'b0, work_data} << step_k;
        lsr_ext  = {work_data, 1'b0} >> step_k;
        asr_ext  = $signed({work_data, 1'b0}) >>> step_k;
        ror_data = (work_data >> step_k) | (work_data << (6'd32 - step_k));
        case (work_type)
            SH_LSL: begin step_data = lsl_ext[31:0];  step_carry = lsl_ext[32]; end
            SH_LSR: begin step_data = lsr_ext[32:1];  step_carry = lsr_ext[0];  end
            SH_ASR: begin step_data = asr_ext[32:1];  step_carry = asr_ext[0];  end
            default: begin step_data = ror_data;      step_carry = ror_data[31]; end
        endcase
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = (eff_count == 6'd0 || is_rrx) ? DONE : SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (remaining == step_k)
                    state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Result is forced to zero outside DONE so idle outputs never leak stale data.
    assign res_data  = res_valid ? work_data  : 32'd0;
    assign res_carry = res_valid ? work_carry : 1'b0;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst || flush) begin
            state      <= IDLE;
            work_type  <= SH_LSL;
            work_data  <= 32'd0;
            work_carry <= 1'b0;
            remaining  <= 6'd0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        work_type <= req_type;
                        remaining <= eff_count;
                        if (is_rrx) begin
                            work_data  <= {req_carry_in, req_data[31:1]};
                            work_carry <= req_data[0];
                        end else begin
                            work_data  <= req_data;
                            work_carry <= req_carry_in;
                        end
                    end
                end
                SHIFT: begin
                    work_data  <= step_data;
                    work_carry <= step_carry;
                    remaining  <= remaining - step_k;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed ARM corner cases with
// literal expectations, then randomized requests against a behavioural model.
module tb_shift_sequencer;

    localparam int STEP = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_data = 32'd0;
    logic [7:0]  req_amount = 8'd0;
    logic        req_carry_in = 1'b0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        res_carry;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    bit          mon_en = 1'b0;
    logic [31:0] mon_data;
    logic        mon_carry;

    shift_sequencer #(.STEP(STEP)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_data(req_data), .req_amount(req_amount), .req_carry_in(req_carry_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_carry(res_carry), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural ARM shifter result, {carry, data}, from the shift rules directly.
    function automatic logic [32:0] model(input logic [1:0] t, input logic rm,
                                          input logic [7:0] amt, input logic [31:0] d,
                                          input logic c);
        int s;
        int r;
        s = rm ? int'(amt) : int'(amt[4:0]);
        if (s == 0) begin
            if (rm || t == 2'd0) return {c, d};
            if (t == 2'd3) return {d[0], c, d[31:1]};
            s = 32;
        end
        case (t)
            2'd0: begin
                if (s > 32)       return 33'd0;
                else if (s == 32) return {d[0], 32'd0};
                else              return {d[32-s], d << s};
            end
            2'd1: begin
                if (s > 32)       return 33'd0;
                else if (s == 32) return {d[31], 32'd0};
                else              return {d[s-1], d >> s};
            end
            2'd2: begin
                if (s >= 32) return {d[31], {32{d[31]}}};
                else         return {d[s-1], 32'($signed(d) >>> s)};
            end
            default: begin
                r = s % 32;
                if (r == 0) return {d[31], d};
                else        return {d[r-1], (d >> r) | (d << (32 - r))};
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [1:0] t, input logic rm, input logic [7:0] amt);
        int s;
        int e;
        s = rm ? int'(amt) : int'(amt[4:0]);
        if (rm) begin
            if (s == 0)       e = 0;
            else if (t <= 1)  e = (s > 33) ? 33 : s;
            else if (t == 2)  e = (s > 32) ? 32 : s;
            else              e = (s % 32 == 0) ? 32 : s % 32;
        end else begin
            if (s != 0)       e = s;
            else if (t == 1 || t == 2) e = 32;
            else              e = 0;
        end
        return 1 + (e + STEP - 1) / STEP;
    endfunction

    // Compare process: whenever a result is presented it must match the model.
    always @(negedge clk) begin
        if (mon_en && res_valid) begin
            check("res_data", 64'(res_data), 64'(mon_data));
            check("res_carry", 64'(res_carry), 64'(mon_carry));
            check("req_ready_in_done", 64'(req_ready), 64'd0);
            check("busy_in_done", 64'(busy), 64'd1);
        end
    end

    // Issue one request from a negedge, wait for its result, apply backpressure, release.
    task automatic run_req(input string name, input logic [1:0] t, input logic rm,
                           input logic [7:0] amt, input logic [31:0] d, input logic c,
                           input logic [31:0] exp_d, input logic exp_c, input int exp_lat,
                           input int hold);
        int lat;
        check({name, "_req_ready"}, 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_op = {t, rm}; req_amount = amt; req_data = d; req_carry_in = c;
        @(posedge clk);
        mon_data = exp_d; mon_carry = exp_c; mon_en = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_data = $urandom;
        lat = 1;
        while (!res_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        // A stray RRX request while DONE must be ignored.
        repeat (hold) begin
            req_valid = 1'b1; req_op = 3'b110; req_amount = 8'd0;
            @(negedge clk);
        end
        req_valid = 1'b1; req_op = 3'b110; req_amount = 8'd0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; req_valid = 1'b0; mon_en = 1'b0;
        check({name, "_release_valid"}, 64'(res_valid), 64'd0);
        check({name, "_release_ready"}, 64'(req_ready), 64'd1);
        check({name, "_release_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_model(input string name, input logic [1:0] t, input logic rm,
                             input logic [7:0] amt, input logic [31:0] d, input logic c,
                             input int hold);
        logic [32:0] m;
        m = model(t, rm, amt, d, c);
        run_req(name, t, rm, amt, d, c, m[31:0], m[32], model_latency(t, rm, amt), hold);
    endtask

    // Abort an LSL #33 request in its second SHIFT cycle via flush or rst.
    task automatic abort_test(input string name, input logic use_rst);
        req_valid = 1'b1; req_op = 3'b001; req_amount = 8'd33;
        req_data = $urandom; req_carry_in = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check({name, "_busy_before"}, 64'(busy), 64'd1);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        check({name, "_valid"}, 64'(res_valid), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_ready"}, 64'(req_ready), 64'd1);
        check({name, "_data"}, {31'd0, res_carry, res_data}, 64'd0);
        run_model({name, "_after"}, 2'd1, 1'b1, 8'd12, 32'hC0FF_EE11, 1'b0, 0);
    endtask

    initial begin
        logic [1:0] t;
        logic       rm;
        logic [7:0] amt;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_valid", 64'(res_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_data", {31'd0, res_carry, res_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_req("lsr_reg4",   2'd1, 1'b1, 8'd4,   32'h8000_00F0, 1'b1, 32'h0800_000F, 1'b0, 2, 0);
        run_req("lsr_imm0",   2'd1, 1'b0, 8'd0,   32'h8000_0001, 1'b0, 32'h0000_0000, 1'b1, 5, 0);
        run_req("lsl_reg32",  2'd0, 1'b1, 8'd32,  32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 5, 0);
        run_req("lsl_reg40",  2'd0, 1'b1, 8'd40,  32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b0, 6, 1);
        run_req("rrx",        2'd3, 1'b0, 8'd0,   32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1, 1, 0);
        run_req("asr_reg200", 2'd2, 1'b1, 8'd200, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 5, 0);
        run_req("ror_reg64",  2'd3, 1'b1, 8'd64,  32'h8000_0001, 1'b0, 32'h8000_0001, 1'b1, 5, 0);
        run_req("ror_reg0",   2'd3, 1'b1, 8'd0,   32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1, 3);
        run_req("lsl_imm0",   2'd0, 1'b0, 8'hE0,  32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1, 0);
        run_req("ror_imm5",   2'd3, 1'b0, 8'd5,   32'h0000_0011, 1'b0, 32'h8800_0000, 1'b1, 2, 0);

        abort_test("flush", 1'b0);
        abort_test("rst", 1'b1);

        for (int i = 0; i < 150; i++) begin
            t  = 2'($urandom_range(0, 3));
            rm = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       amt = 8'd0;
                1:       amt = 8'($urandom_range(1, 31));
                2:       amt = 8'd32;
                3:       amt = 8'd33;
                4:       amt = 8'd64;
                default: amt = 8'($urandom_range(0, 255));
            endcase
            run_model("rand", t, rm, amt, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

endmodule
